// File: rtl/midori_sbox_serial_driver_if.sv
// Bundle of every signal the serial S-box driver exchanges with the round
// controller (start/done, state shares, randomness) and with the masked S-box.
// master = the driver itself, slave = the surrounding logic.
interface midori_sbox_serial_driver_if #(
  parameter int NIB = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic [4*NIB-1:0] st1_i;
  logic [4*NIB-1:0] st2_i;
  logic [4*NIB-1:0] st3_i;
  logic [4*NIB-1:0] st1_o;
  logic [4*NIB-1:0] st2_o;
  logic [4*NIB-1:0] st3_o;
  logic [95:0]      rnd_i;
  logic             rnd_valid;
  logic             rnd_ack;
  logic [3:0]       sb_in1;
  logic [3:0]       sb_in2;
  logic [3:0]       sb_in3;
  logic [7:0]       sb_neigh;
  logic [95:0]      sb_r;
  logic [3:0]       sb_out1;
  logic [3:0]       sb_out2;
  logic [3:0]       sb_out3;

  modport master (
    input  start, st1_i, st2_i, st3_i, rnd_i, rnd_valid,
           sb_out1, sb_out2, sb_out3,
    output busy, done, st1_o, st2_o, st3_o, rnd_ack,
           sb_in1, sb_in2, sb_in3, sb_neigh, sb_r
  );

  modport slave (
    output start, st1_i, st2_i, st3_i, rnd_i, rnd_valid,
           sb_out1, sb_out2, sb_out3,
    input  busy, done, st1_o, st2_o, st3_o, rnd_ack,
           sb_in1, sb_in2, sb_in3, sb_neigh, sb_r
  );
endinterface

// File: rtl/midori_sbox_serial_driver.sv
// Serial SubCell stage: pushes one nibble of a 3-share Midori state per
// issue cycle through a single registered masked S-box and reassembles the
// output shares. An issue only happens when fresh randomness is offered, so
// the S-box never sees stale shares or reused masks.
module midori_sbox_serial_driver #(
  parameter int NIB = 16
) (
  input  logic                          clk,
  input  logic                          rst_i,
  midori_sbox_serial_driver_if.master   bus
);

  localparam int IW = $clog2(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);
  localparam logic [IW:0]   LAST_CAP = (IW + 1)'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [4*NIB-1:0] in1, in2, in3;
  logic [4*NIB-1:0] out1, out2, out3;
  logic [IW-1:0]    issue_cnt;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    nidx;
  logic [IW:0]      cap_cnt;
  logic             vld_q;
  logic             issue;

  // neighbour nibble index, wrapping the last nibble back to nibble 0
  assign nidx = (issue_cnt == LAST_IDX) ? '0 : issue_cnt + 1'b1;

  assign bus.busy  = (state == RUN) || (state == DRAIN);
  assign bus.done  = (state == DONE);
  assign bus.st1_o = out1;
  assign bus.st2_o = out2;
  assign bus.st3_o = out3;

  // state register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and S-box drive; the S-box ports are zero unless issuing
  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    bus.rnd_ack  = 1'b0;
    bus.sb_in1   = '0;
    bus.sb_in2   = '0;
    bus.sb_in3   = '0;
    bus.sb_neigh = '0;
    bus.sb_r     = '0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        if (bus.rnd_valid) begin
          issue        = 1'b1;
          bus.rnd_ack  = 1'b1;
          bus.sb_in1   = in1[4*issue_cnt +: 4];
          bus.sb_in2   = in2[4*issue_cnt +: 4];
          bus.sb_in3   = in3[4*issue_cnt +: 4];
          bus.sb_neigh = {in2[4*nidx +: 4], in1[4*nidx +: 4]};
          bus.sb_r     = bus.rnd_i;
          if (issue_cnt == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_q && cap_cnt == LAST_CAP) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // input-share snapshot, issue counter and the one-deep issue pipeline tag
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      in1       <= '0;
      in2       <= '0;
      in3       <= '0;
      issue_cnt <= '0;
      vld_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        in1       <= bus.st1_i;
        in2       <= bus.st2_i;
        in3       <= bus.st3_i;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      vld_q <= issue;
      idx_q <= issue_cnt;
    end
  end

  // capture the S-box result one cycle after its issue
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      out1    <= '0;
      out2    <= '0;
      out3    <= '0;
      cap_cnt <= '0;
    end else begin
      if (vld_q) begin
        out1[4*idx_q +: 4] <= bus.sb_out1;
        out2[4*idx_q +: 4] <= bus.sb_out2;
        out3[4*idx_q +: 4] <= bus.sb_out3;
        cap_cnt            <= cap_cnt + 1'b1;
      end
      if (state == IDLE && bus.start) cap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_midori_sbox_serial_driver.sv
// Testbench for the serial S-box driver. A behavioural registered S-box
// (output share 1 carries S(x) re-masked with two random nibbles) closes the
// loop so the recombined output can be checked against known answers.
module tb_midori_sbox_serial_driver;

  localparam int NIB = 16;
  localparam logic [63:0] KAT_IN  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_OUT = 64'hCAD3EBF789150246;
  localparam logic [63:0] REV_IN  = 64'hFEDCBA9876543210;
  localparam logic [63:0] REV_OUT = 64'h642051987FBE3DAC;
  localparam logic [63:0] ONE_IN  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] ONE_OUT = 64'h6666666666666666;

  typedef struct {
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    bit          stall;
    logic [63:0] exp_xor;
    int          done_at;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  midori_sbox_serial_driver_if #(.NIB(NIB)) bus ();

  midori_sbox_serial_driver #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'hA;  4'h2: return 4'hD;  4'h3: return 4'h3;
      4'h4: return 4'hE;  4'h5: return 4'hB;  4'h6: return 4'hF;  4'h7: return 4'h7;
      4'h8: return 4'h8;  4'h9: return 4'h9;  4'hA: return 4'h1;  4'hB: return 4'h5;
      4'hC: return 4'h0;  4'hD: return 4'h2;  4'hE: return 4'h4;  default: return 4'h6;
    endcase
  endfunction

  // registered masked S-box stand-in
  always_ff @(posedge clk) begin
    bus.sb_out1 <= sbox(bus.sb_in1 ^ bus.sb_in2 ^ bus.sb_in3) ^ bus.sb_r[3:0] ^ bus.sb_r[7:4];
    bus.sb_out2 <= bus.sb_r[3:0];
    bus.sb_out3 <= bus.sb_r[7:4];
  end

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet(input string name);
    checkOutput({name, "_ack"}, bus.rnd_ack, 1'b0);
    checkOutput({name, "_sb"}, {bus.sb_in1, bus.sb_in2, bus.sb_in3, bus.sb_neigh}, 20'h0);
    checkOutput({name, "_r"}, bus.sb_r, 96'h0);
  endtask

  // one full run from acceptance to done, checking every cycle against the table record
  task automatic applyStimulus(input vec_t v, input int id);
    int cyc;
    int acks;
    int n;
    bit seen_done;
    next_cycle();
    bus.st1_i     = v.s1;
    bus.st2_i     = v.s2;
    bus.st3_i     = v.s3;
    bus.start     = 1'b1;
    bus.rnd_valid = 1'b0;
    #1;
    checkOutput($sformatf("v%0d_idle_busy", id), bus.busy, 1'b0);
    cyc = 0;
    acks = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 60) begin
      next_cycle();
      cyc++;
      bus.start     = 1'b0;
      bus.rnd_valid = v.stall ? ~cyc[0] : 1'b1;
      bus.rnd_i     = {$urandom, $urandom, $urandom};
      #1;
      checkOutput($sformatf("v%0d_ack_c%0d", id, cyc), bus.rnd_ack,
                  (bus.rnd_valid && acks < 16) ? 1'b1 : 1'b0);
      if (bus.rnd_ack) begin
        n = (acks + 1) % 16;
        checkOutput($sformatf("v%0d_in_k%0d", id, acks), {bus.sb_in1, bus.sb_in2, bus.sb_in3},
                    {v.s1[4*acks +: 4], v.s2[4*acks +: 4], v.s3[4*acks +: 4]});
        checkOutput($sformatf("v%0d_neigh_k%0d", id, acks), bus.sb_neigh,
                    {v.s2[4*n +: 4], v.s1[4*n +: 4]});
        checkOutput($sformatf("v%0d_r_k%0d", id, acks), bus.sb_r, bus.rnd_i);
        acks++;
      end else begin
        check_quiet($sformatf("v%0d_stall_c%0d", id, cyc));
      end
      if (bus.done) begin
        seen_done = 1'b1;
        checkOutput($sformatf("v%0d_done_cycle", id), cyc, v.done_at);
        checkOutput($sformatf("v%0d_done_busy", id), bus.busy, 1'b0);
        checkOutput($sformatf("v%0d_xor", id), bus.st1_o ^ bus.st2_o ^ bus.st3_o, v.exp_xor);
      end else begin
        checkOutput($sformatf("v%0d_busy_c%0d", id, cyc), bus.busy, 1'b1);
      end
    end
    checkOutput($sformatf("v%0d_done_seen", id), seen_done, 1'b1);
    checkOutput($sformatf("v%0d_ack_count", id), acks, 16);
  endtask

  vec_t vecs[5];
  logic [63:0] m2, m3;
  int acks;
  int cyc;

  initial begin
    m2 = {$urandom, $urandom};
    m3 = {$urandom, $urandom};
    vecs[0] = '{KAT_IN, 64'h0, 64'h0, 1'b0, KAT_OUT, 18};
    vecs[1] = '{KAT_IN ^ m2 ^ m3, m2, m3, 1'b0, KAT_OUT, 18};
    vecs[2] = '{KAT_IN, 64'h0, 64'h0, 1'b1, KAT_OUT, 34};
    vecs[3] = '{REV_IN ^ m3, 64'h0, m3, 1'b0, REV_OUT, 18};
    vecs[4] = '{64'h0, m2, m2, 1'b1, 64'hCCCCCCCCCCCCCCCC, 34};

    rst_i         = 1'b1;
    bus.start     = 1'b0;
    bus.st1_i     = '0;
    bus.st2_i     = '0;
    bus.st3_i     = '0;
    bus.rnd_i     = '0;
    bus.rnd_valid = 1'b1;
    next_cycle();
    next_cycle();
    checkOutput("rst_busy_done", {bus.busy, bus.done}, 2'b00);
    checkOutput("rst_st_o", {bus.st1_o, bus.st2_o, bus.st3_o}, 192'h0);
    check_quiet("rst");
    rst_i = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // reset in the middle of a run: the cycle issuing nibble 7
    next_cycle();
    bus.st1_i = KAT_IN; bus.st2_i = '0; bus.st3_i = '0;
    bus.start = 1'b1;
    acks = 0;
    cyc = 0;
    while (acks < 7 && cyc < 30) begin
      next_cycle();
      cyc++;
      bus.start = 1'b0;
      bus.rnd_valid = 1'b1;
      bus.rnd_i = {$urandom, $urandom, $urandom};
      #1;
      if (bus.rnd_ack) acks++;
    end
    next_cycle();
    #1;
    checkOutput("mid_ack_before_rst", bus.rnd_ack, 1'b1);
    rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_busy_done", {bus.busy, bus.done}, 2'b00);
    checkOutput("mid_rst_st_o", {bus.st1_o, bus.st2_o, bus.st3_o}, 192'h0);
    check_quiet("mid_rst");
    next_cycle();
    rst_i = 1'b0;
    for (int c = 0; c < 25; c++) begin
      next_cycle();
      #1;
      checkOutput($sformatf("after_rst_done_c%0d", c), bus.done, 1'b0);
    end
    applyStimulus(vecs[0], 10);

    // start held high: accepted in T, T+19, T+38; st_i changes while busy are ignored
    next_cycle();
    bus.st1_i = KAT_IN; bus.st2_i = '0; bus.st3_i = '0;
    bus.start = 1'b1;
    bus.rnd_valid = 1'b1;
    for (int c = 1; c <= 57; c++) begin
      next_cycle();
      bus.rnd_i = {$urandom, $urandom, $urandom};
      if (c == 5) bus.st1_i = ONE_IN;
      bus.start = (c < 56) ? 1'b1 : 1'b0;
      #1;
      checkOutput($sformatf("b2b_done_c%0d", c), bus.done,
                  (c == 18 || c == 37 || c == 56) ? 1'b1 : 1'b0);
      checkOutput($sformatf("b2b_busy_c%0d", c), bus.busy,
                  ((c >= 1 && c <= 17) || (c >= 20 && c <= 36) || (c >= 39 && c <= 55)) ? 1'b1 : 1'b0);
      if (c == 18) checkOutput("b2b_xor_1", bus.st1_o ^ bus.st2_o ^ bus.st3_o, KAT_OUT);
      if (c == 37) checkOutput("b2b_xor_2", bus.st1_o ^ bus.st2_o ^ bus.st3_o, ONE_OUT);
    end

    // idle with randomness on offer: nothing may move
    bus.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      bus.rnd_valid = 1'b1;
      bus.rnd_i = {$urandom, $urandom, $urandom};
      #1;
      check_quiet($sformatf("idle_c%0d", c));
      checkOutput($sformatf("idle_xor_c%0d", c), bus.st1_o ^ bus.st2_o ^ bus.st3_o, ONE_OUT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
